// File: rtl/demux1to4_2bit_reg_pkg.sv
// Shared types and constants for the registered 1-to-4 2-bit demultiplexer.
package demux1to4_2bit_reg_pkg;

  typedef logic [1:0] ch_idx_t;

  localparam ch_idx_t CH_U = 2'd0;
  localparam ch_idx_t CH_V = 2'd1;
  localparam ch_idx_t CH_W = 2'd2;
  localparam ch_idx_t CH_X = 2'd3;

  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_RR   = 1'b1;

  typedef enum logic [1:0] {
    RR_CH0 = 2'd0,
    RR_CH1 = 2'd1,
    RR_CH2 = 2'd2,
    RR_CH3 = 2'd3
  } rr_state_e;

  function automatic logic [3:0] ch_onehot(input ch_idx_t ch);
    logic [3:0] oh;
    oh = '0;
    oh[ch] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/demux1to4_2bit_reg_rr_pointer.sv
// Round-robin channel pointer: wraps CH0..CH3, held at CH0 outside round-robin mode,
// and pulses frame_done one cycle after a transfer into CH3.
module rr_pointer
  import demux1to4_2bit_reg_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    mode,
  input  logic    advance,
  output ch_idx_t ptr,
  output logic    frame_done
);

  rr_state_e state, state_nxt;
  logic      fd_q, fd_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RR_CH0;
      fd_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      fd_q  <= fd_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fd_nxt    = 1'b0;
    if (mode != MODE_RR) begin
      // Leaving round-robin abandons any partial frame.
      state_nxt = RR_CH0;
    end else if (advance) begin
      fd_nxt = (state == RR_CH3);
      unique case (state)
        RR_CH0:  state_nxt = RR_CH1;
        RR_CH1:  state_nxt = RR_CH2;
        RR_CH2:  state_nxt = RR_CH3;
        RR_CH3:  state_nxt = RR_CH0;
        default: state_nxt = RR_CH0;
      endcase
    end
  end

  always_comb begin
    ptr        = ch_idx_t'(state);
    frame_done = fd_q;
  end

endmodule

// File: rtl/demux1to4_2bit_reg.sv
// Registered 1-to-4 demultiplexer: steers each accepted sample into one of four
// held channels, addressed by select or stepped round-robin, with per-channel acks.
module demux1to4_2bit_reg
  import demux1to4_2bit_reg_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [1:0]       select,
  input  logic [3:0]       rd_ack,
  output logic [WIDTH-1:0] U,
  output logic [WIDTH-1:0] V,
  output logic [WIDTH-1:0] W,
  output logic [WIDTH-1:0] X,
  output logic [3:0]       out_valid,
  output logic [1:0]       cur_ch,
  output logic             frame_done
);

  logic [WIDTH-1:0] ch_q [4];
  logic [3:0]       valid_q;
  ch_idx_t          ptr;
  ch_idx_t          target;
  logic             xfer;
  logic [3:0]       wr_oh;

  always_comb begin
    target   = (mode == MODE_RR) ? ptr : ch_idx_t'(select);
    // An ack on the occupied target frees it in the same cycle it is rewritten.
    in_ready = ~reset & (~valid_q[target] | rd_ack[target]);
    xfer     = in_valid & in_ready;
    wr_oh    = xfer ? ch_onehot(target) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < 4; k++) begin
        ch_q[k] <= '0;
      end
      valid_q <= '0;
    end else begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (wr_oh[k]) begin
          ch_q[k]    <= in_data;
          valid_q[k] <= 1'b1;
        end else if (rd_ack[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
    end
  end

  rr_pointer u_rr_pointer (
    .clk        (clk),
    .reset      (reset),
    .mode       (mode),
    .advance    (xfer),
    .ptr        (ptr),
    .frame_done (frame_done)
  );

  always_comb begin
    U         = ch_q[CH_U];
    V         = ch_q[CH_V];
    W         = ch_q[CH_W];
    X         = ch_q[CH_X];
    out_valid = valid_q;
    cur_ch    = target;
  end

endmodule

// File: tb/tb_demux1to4_2bit_reg.sv
// Self-checking bench: per-cycle comparison against a behavioural model plus directed literal checks.
module tb_demux1to4_2bit_reg;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       mode = 1'b0;
  logic [1:0] select = '0;
  logic [3:0] rd_ack = '0;
  logic [1:0] U, V, W, X;
  logic [3:0] out_valid;
  logic [1:0] cur_ch;
  logic       frame_done;

  int passes = 0;
  int total  = 0;
  bit chk_en = 1'b0;

  int m_data [4];
  bit m_valid [4];
  int m_ptr = 0;
  bit m_fd = 1'b0;

  always #5 clk = ~clk;

  demux1to4_2bit_reg #(.WIDTH(2)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .select(select), .rd_ack(rd_ack),
    .U(U), .V(V), .W(W), .X(X), .out_valid(out_valid), .cur_ch(cur_ch),
    .frame_done(frame_done)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int m_target();
    return mode ? m_ptr : int'(select);
  endfunction

  function automatic bit m_ready();
    int t;
    t = m_target();
    return !reset && (!m_valid[t] || rd_ack[t]);
  endfunction

  function automatic int m_valid_vec();
    int v = 0;
    for (int k = 0; k < 4; k++) if (m_valid[k]) v += (1 << k);
    return v;
  endfunction

  // Model: one sample moves to one channel per accepted handshake.
  always @(posedge clk) begin
    int  t;
    bit  acc;
    t   = m_target();
    acc = in_valid && m_ready();
    if (reset) begin
      for (int k = 0; k < 4; k++) begin m_data[k] = 0; m_valid[k] = 0; end
      m_ptr = 0;
      m_fd  = 0;
    end else begin
      m_fd = acc && mode && (t == 3);
      for (int k = 0; k < 4; k++) begin
        if (acc && t == k) begin m_data[k] = int'(in_data); m_valid[k] = 1; end
        else if (rd_ack[k]) m_valid[k] = 0;
      end
      if (!mode) m_ptr = 0;
      else if (acc) m_ptr = (m_ptr + 1) % 4;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_U", int'(U), m_data[0]);
      chk("cmp_V", int'(V), m_data[1]);
      chk("cmp_W", int'(W), m_data[2]);
      chk("cmp_X", int'(X), m_data[3]);
      chk("cmp_out_valid", int'(out_valid), m_valid_vec());
      chk("cmp_in_ready", int'(in_ready), int'(m_ready()));
      chk("cmp_cur_ch", int'(cur_ch), m_target());
      chk("cmp_frame_done", int'(frame_done), int'(m_fd));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc();
    chk_en = 1'b1;
    cyc();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_U", int'(U), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    reset = 1'b0;

    // 1: addressed write to W
    mode = 1'b0; select = 2'b10; in_data = 2'b11; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("t1_W", int'(W), 3);
    chk("t1_out_valid", int'(out_valid), 4);
    chk("t1_UVX", int'({U, V, X}), 0);

    // 2: occupied U blocks until acked
    select = 2'b00; in_data = 2'b01; in_valid = 1'b1;
    cyc();
    chk("t2_U_first", int'(U), 1);
    in_data = 2'b10;
    #1 chk("t2_blocked", int'(in_ready), 0);
    cyc();
    chk("t2_U_held", int'(U), 1);
    rd_ack = 4'b0001;
    #1 chk("t2_ack_ready", int'(in_ready), 1);
    cyc();
    chk("t2_U_new", int'(U), 2);
    chk("t2_valid0", int'(out_valid[0]), 1);
    in_valid = 1'b0; rd_ack = '0;

    // 3: round-robin frame with all channels acked
    mode = 1'b1; rd_ack = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      in_data = 2'(i); in_valid = 1'b1;
      #1 chk("t3_cur_ch", int'(cur_ch), i);
      cyc();
      chk("t3_frame_done", int'(frame_done), (i == 3) ? 1 : 0);
    end
    in_valid = 1'b0;
    chk("t3_cur_ch_wrap", int'(cur_ch), 0);
    chk("t3_data", int'({X, W, V, U}), 8'b11_10_01_00);
    cyc();
    chk("t3_fd_one_cycle", int'(frame_done), 0);
    rd_ack = '0;

    // 4: abandoned partial frame
    in_valid = 1'b1; in_data = 2'b01;
    cyc();
    in_data = 2'b10;
    cyc();
    in_valid = 1'b0; mode = 1'b0; select = 2'b11;
    #1 chk("t4_cur_ch_addr", int'(cur_ch), 3);
    cyc();
    chk("t4_no_fd", int'(frame_done), 0);
    mode = 1'b1;
    #1 chk("t4_ptr_zero", int'(cur_ch), 0);
    rd_ack = 4'b0001; in_data = 2'b11; in_valid = 1'b1;
    cyc();
    chk("t4_U", int'(U), 3);
    chk("t4_V_kept", int'(V), 2);
    in_valid = 1'b0; rd_ack = '0;

    // 5: fill everything, then reset with a pending write and acks
    mode = 1'b0;
    for (int s = 0; s < 4; s++) begin
      select = 2'(s); in_data = 2'(3 - s); in_valid = 1'b1;
      rd_ack = 4'(1 << s);
      cyc();
    end
    in_valid = 1'b0; rd_ack = '0;
    chk("t5_full", int'(out_valid), 15);
    reset = 1'b1; in_valid = 1'b1; rd_ack = 4'b1111;
    #1 chk("t5_ready_in_reset", int'(in_ready), 0);
    cyc();
    chk("t5_cleared", int'({U, V, W, X, out_valid}), 0);
    reset = 1'b0; in_valid = 1'b0; rd_ack = '0;

    // 6: stray ack, then selective ack
    rd_ack = 4'b0010;
    cyc();
    chk("t6_stray_ack", int'(out_valid), 0);
    rd_ack = '0; select = 2'b01; in_data = 2'b10; in_valid = 1'b1;
    cyc();
    select = 2'b11; in_data = 2'b01;
    cyc();
    in_valid = 1'b0; rd_ack = 4'b0010;
    cyc();
    rd_ack = '0;
    chk("t6_valid", int'(out_valid), 8);
    chk("t6_V_held", int'(V), 2);
    chk("t6_X", int'(X), 1);
    cyc();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
